// File: rtl/hall98_pkg.sv
// Shared definitions for the hall98 issue interface: opcodes, register codes,
// program word layout, issue bundle and issuer state encoding.
package hall98_pkg;

    localparam logic [1:0] OP_MOV = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b11;
    localparam logic [1:0] OP_MUL = 2'b00;

    localparam logic [2:0] REG_H = 3'd1;
    localparam logic [2:0] REG_A = 3'd2;
    localparam logic [2:0] REG_L = 3'd3;
    localparam logic [2:0] REG_N = 3'd4;

    // Program word: {last, op[1:0], nop, re[2:0], n[31:0]}
    localparam int WORD_W  = 39;
    localparam int W_LAST  = 38;
    localparam int W_OP_HI = 37;
    localparam int W_OP_LO = 36;
    localparam int W_NOP   = 35;
    localparam int W_RE_HI = 34;
    localparam int W_RE_LO = 32;
    localparam int W_N_HI  = 31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } issuer_state_e;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] re;
        logic [31:0] n;
        logic        flag;
    } issue_t;

    localparam issue_t BUBBLE = '{op: 2'b00, re: 32'd0, n: 32'd0, flag: 1'b1};

    function automatic issue_t decode_word(input logic [WORD_W-1:0] word);
        issue_t r;
        if (word[W_NOP]) begin
            r = BUBBLE;
        end else begin
            r.op   = word[W_OP_HI:W_OP_LO];
            r.re   = {29'd0, word[W_RE_HI:W_RE_LO]};
            r.n    = word[W_N_HI:0];
            r.flag = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/hall98_prog_mem.sv
// Program store for the issuer: synchronous write port, combinational read port.
module hall98_prog_mem
    import hall98_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem_r [DEPTH];

    // Program words are deliberately left unreset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/hall98_issuer.sv
// Instruction sequencer for the hall98 core: issues program words one slot at a time,
// inserting bubbles for gaps, pauses and whenever it is not running.
module hall98_issuer
    import hall98_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int ISSUE_GAP = 0
) (
    input  logic              iclock,
    input  logic              ireset_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    output logic              sw1,
    output logic              sw2,
    output logic [31:0]       re,
    output logic [31:0]       n,
    output logic              flag,
    output logic [AW-1:0]     pc,
    output logic [16:0]       issued,
    output logic              busy,
    output logic              done,
    output logic              wr_err
);

    localparam logic [3:0]    GAP_W  = 4'(ISSUE_GAP);
    localparam logic [AW-1:0] PC_MAX = AW'(DEPTH - 1);

    issuer_state_e     state_r;
    logic [3:0]        gap_r;
    logic              fin_r;
    issue_t            out_r;
    logic [WORD_W-1:0] rd_word_s;
    logic              run_s;
    logic              mem_we_s;
    logic              fin_s;

    assign run_s    = (state_r == ST_RUN) || (state_r == ST_PAUSE);
    assign mem_we_s = wr_en && !run_s;
    assign fin_s    = rd_word_s[W_LAST] || (pc == PC_MAX);

    hall98_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk     (iclock),
        .we      (mem_we_s),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (pc),
        .rd_data (rd_word_s)
    );

    assign sw1  = out_r.op[1];
    assign sw2  = out_r.op[0];
    assign re   = out_r.re;
    assign n    = out_r.n;
    assign flag = out_r.flag;

    // Issuer FSM: slot/gap sequencing, pause freeze, abort, and all registered outputs
    always_ff @(posedge iclock or negedge ireset_n) begin
        if (!ireset_n) begin
            state_r <= ST_IDLE;
            pc      <= '0;
            gap_r   <= 4'd0;
            fin_r   <= 1'b0;
            issued  <= 17'd0;
            out_r   <= BUBBLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_err  <= 1'b0;
        end else begin
            wr_err <= wr_en && run_s;
            if (abort) begin
                state_r <= ST_IDLE;
                pc      <= '0;
                gap_r   <= 4'd0;
                fin_r   <= 1'b0;
                out_r   <= BUBBLE;
                busy    <= 1'b0;
                done    <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE, ST_DONE: begin
                        out_r <= BUBBLE;
                        // A write in the same cycle swallows the start
                        if (start && !wr_en) begin
                            state_r <= ST_RUN;
                            pc      <= '0;
                            gap_r   <= 4'd0;
                            fin_r   <= 1'b0;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                        end
                    end
                    ST_RUN, ST_PAUSE: begin
                        if (pause) begin
                            state_r <= ST_PAUSE;
                            out_r   <= BUBBLE;
                        end else if (gap_r != 4'd0) begin
                            out_r <= BUBBLE;
                            gap_r <= gap_r - 4'd1;
                            // The final word's trailing gap completes before DONE
                            if ((gap_r == 4'd1) && fin_r) begin
                                state_r <= ST_DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                state_r <= ST_RUN;
                            end
                        end else begin
                            out_r <= decode_word(rd_word_s);
                            if (!rd_word_s[W_NOP]) begin
                                issued <= issued + 17'd1;
                            end
                            if (pc != PC_MAX) begin
                                pc <= pc + AW'(1);
                            end
                            gap_r <= GAP_W;
                            fin_r <= fin_s;
                            if (fin_s && (GAP_W == 4'd0)) begin
                                state_r <= ST_DONE;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                state_r <= ST_RUN;
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        out_r   <= BUBBLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
